// File: rtl/qmux_switch_ctrl.sv
// Parametrised quad global mux with break-before-make select sequencing, FORCE override and error flag.
// Define QMUX_SWITCH_CNT_EN to add the saturating completed-switch counter (SW_CNT / SW_CNT_CLR).
module qmux_switch_ctrl #(
  parameter int NUM_IN     = 4,
  parameter int SEL_W      = 2,
  parameter int DEF_SEL    = 0,
  parameter int FORCE_CH   = NUM_IN - 1,
  parameter int GAP_CYC    = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_IN-1:0] MUXIN,
  input  logic [SEL_W-1:0]  SEL_REQ,
  input  logic              SEL_VALID,
  output logic              SEL_READY,
  input  logic              FORCE,
  output logic              IZ,
  output logic [SEL_W-1:0]  SEL_CUR,
  output logic              BUSY,
  output logic              ERR
`ifdef QMUX_SWITCH_CNT_EN
  ,
  input  logic              SW_CNT_CLR,
  output logic [15:0]       SW_CNT
`endif
);

  localparam int CNT_MAX = (GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int MUX_W   = 2 ** SEL_W;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] DEF_S    = SEL_W'(DEF_SEL);
  localparam logic [SEL_W-1:0] FORCE_S  = SEL_W'(FORCE_CH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SETTLE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_sel_cur;
  logic [SEL_W-1:0]   r_sel_saved;
  logic [SEL_W-1:0]   r_target;
  logic               r_err;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   w_sel_cur_nxt;
  logic [SEL_W-1:0]   w_sel_saved_nxt;
  logic [SEL_W-1:0]   w_target_nxt;
  logic               w_err_nxt;
  logic               w_en;
  logic               w_force_pending;
  logic               w_accept;
  logic               w_req_bad;
  logic [MUX_W-1:0]   w_mux_pad;

  // Out-of-range requests only exist when the select space is larger than the source count.
  if (NUM_IN < MUX_W) begin : g_range_chk
    assign w_req_bad = (SEL_REQ >= SEL_W'(NUM_IN));
  end else begin : g_range_full
    assign w_req_bad = 1'b0;
  end

  assign w_en            = (r_state == S_RUN);
  assign w_force_pending = (r_sel_cur != r_sel_saved);
  assign w_accept        = SEL_VALID && SEL_READY;
  assign w_mux_pad       = MUX_W'(MUXIN);

  assign SEL_READY = w_en && !FORCE && !w_force_pending;
  assign IZ        = w_en & w_mux_pad[r_sel_cur];
  assign SEL_CUR   = r_sel_cur;
  assign BUSY      = !w_en;
  assign ERR       = r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_sel_cur   <= DEF_S;
      r_sel_saved <= DEF_S;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sel_cur   <= w_sel_cur_nxt;
      r_sel_saved <= w_sel_saved_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // The pending target is only consumed after a state transition, so it needs no reset.
  always_ff @(posedge CLK) begin
    r_target <= w_target_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sel_cur_nxt   = r_sel_cur;
    w_sel_saved_nxt = r_sel_saved;
    w_target_nxt    = r_target;
    w_err_nxt       = 1'b0;
    case (r_state)
      S_RUN: begin
        if (FORCE && (r_sel_cur != FORCE_S)) begin
          w_target_nxt = FORCE_S;
          w_state_nxt  = S_DRAIN;
          w_cnt_nxt    = '0;
        end else if (!FORCE && w_force_pending) begin
          w_target_nxt = r_sel_saved;
          w_state_nxt  = S_DRAIN;
          w_cnt_nxt    = '0;
        end else if (w_accept) begin
          if (w_req_bad) begin
            w_err_nxt = 1'b1;
          end else if (SEL_REQ != r_sel_cur) begin
            w_sel_saved_nxt = SEL_REQ;
            w_target_nxt    = SEL_REQ;
            w_state_nxt     = S_DRAIN;
            w_cnt_nxt       = '0;
          end
        end
      end
      S_DRAIN: begin
        if (r_cnt == GAP_LAST) begin
          w_sel_cur_nxt = r_target;
          w_state_nxt   = S_SETTLE;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (r_cnt == SET_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef QMUX_SWITCH_CNT_EN
  logic [15:0] r_sw_cnt;
  logic        w_sw_done;

  assign w_sw_done = (r_state == S_SETTLE) && (r_cnt == SET_LAST);
  assign SW_CNT    = r_sw_cnt;

  // Clear takes priority over a switch completing on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sw_cnt <= 16'h0000;
    end else if (SW_CNT_CLR) begin
      r_sw_cnt <= 16'h0000;
    end else if (w_sw_done && (r_sw_cnt != 16'hFFFF)) begin
      r_sw_cnt <= r_sw_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_qmux_switch_ctrl.sv
// Bench for qmux_switch_ctrl: a 4-source instance (A) and a 3-source instance (B) sharing clock, reset and sources.
`timescale 1ns/1ps
module tb_qmux_switch_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] muxin = 4'b0000;
  logic [2:0] muxin_b;
  logic [1:0] req_a = 2'd0, req_b = 2'd0;
  logic       vld_a = 1'b0, vld_b = 1'b0, frc_a = 1'b0, frc_b = 1'b0;
  logic       rdy_a, rdy_b, iz_a, iz_b, busy_a, busy_b, err_a, err_b;
  logic [1:0] sel_a, sel_b;
`ifdef QMUX_SWITCH_CNT_EN
  logic        clr = 1'b0;
  logic [15:0] cnt_a, cnt_b;
`endif

  assign muxin_b = muxin[2:0];

  always #5 CLK = ~CLK;

  qmux_switch_ctrl #(.NUM_IN(4), .SEL_W(2)) u_a (
    .CLK(CLK), .RST(RST), .MUXIN(muxin), .SEL_REQ(req_a), .SEL_VALID(vld_a),
    .SEL_READY(rdy_a), .FORCE(frc_a), .IZ(iz_a), .SEL_CUR(sel_a), .BUSY(busy_a), .ERR(err_a)
`ifdef QMUX_SWITCH_CNT_EN
    , .SW_CNT_CLR(clr), .SW_CNT(cnt_a)
`endif
  );

  qmux_switch_ctrl #(.NUM_IN(3), .SEL_W(2)) u_b (
    .CLK(CLK), .RST(RST), .MUXIN(muxin_b), .SEL_REQ(req_b), .SEL_VALID(vld_b),
    .SEL_READY(rdy_b), .FORCE(frc_b), .IZ(iz_b), .SEL_CUR(sel_b), .BUSY(busy_b), .ERR(err_b)
`ifdef QMUX_SWITCH_CNT_EN
    , .SW_CNT_CLR(clr), .SW_CNT(cnt_b)
`endif
  );

  typedef struct {
    bit         on_b;
    logic [1:0] req;
    logic [3:0] mux;
    logic [1:0] exp_sel;
    int         exp_err;
    int         exp_busy;
    logic       exp_iz;
  } vec_t;

  vec_t tbl[10];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic req_sw_a(input logic [1:0] r);
    step();
    req_a = r;
    vld_a = 1'b1;
    step();
    vld_a = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 2'd1, 4'b0010, 2'd1, 0, 4, 1'b1};
    tbl[1] = '{1'b0, 2'd1, 4'b1101, 2'd1, 0, 0, 1'b0};
    tbl[2] = '{1'b0, 2'd3, 4'b1000, 2'd3, 0, 4, 1'b1};
    tbl[3] = '{1'b0, 2'd0, 4'b1110, 2'd0, 0, 4, 1'b0};
    tbl[4] = '{1'b1, 2'd0, 4'b0001, 2'd0, 0, 0, 1'b1};
    tbl[5] = '{1'b1, 2'd3, 4'b0110, 2'd0, 1, 0, 1'b0};
    tbl[6] = '{1'b1, 2'd2, 4'b0100, 2'd2, 0, 4, 1'b1};
    tbl[7] = '{1'b1, 2'd3, 4'b0011, 2'd2, 1, 0, 1'b0};
    tbl[8] = '{1'b1, 2'd2, 4'b0111, 2'd2, 0, 0, 1'b1};
    tbl[9] = '{1'b0, 2'd2, 4'b0100, 2'd2, 0, 4, 1'b1};

    // Reset: IZ follows MUXIN[DEF_SEL] while RST is held and after release
    muxin = 4'b0001;
    #1 RST = 1'b1;
    #2;
    chk("rst_iz_during", iz_a, 1);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_iz", iz_a, 1);
    chk("rst_sel", sel_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_rdy", rdy_a, 1);
    chk("rst_err", err_a, 0);
    chk("rst_sel_b", sel_b, 0);

    // Normal 0->2 switch, edge-by-edge
    step();
    muxin = 4'b0101;
    req_a = 2'd2;
    vld_a = 1'b1;
    @(negedge CLK);
    chk("sw_rdy", rdy_a, 1);
    chk("sw_iz_pre", iz_a, 1);
    step();
    vld_a = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      chk($sformatf("sw_iz_e%0d", k), iz_a, (k < 4) ? 0 : 1);
      chk($sformatf("sw_sel_e%0d", k), sel_a, (k < 2) ? 0 : 2);
      chk($sformatf("sw_busy_e%0d", k), busy_a, (k < 4) ? 1 : 0);
      if (k < 4) step();
    end

    // Override from source 1 to FORCE_CH=3 and back
    req_sw_a(2'd1);
    muxin = 4'b1010;
    step();
    frc_a = 1'b1;
    vld_a = 1'b1;
    req_a = 2'd0;
    @(negedge CLK);
    chk("frc_rdy", rdy_a, 0);
    step();
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      chk($sformatf("frc_busy_e%0d", k), busy_a, (k < 4) ? 1 : 0);
      chk($sformatf("frc_sel_e%0d", k), sel_a, (k < 2) ? 1 : 3);
      chk($sformatf("frc_iz_e%0d", k), iz_a, (k < 4) ? 0 : 1);
      if (k < 4) step();
    end
    repeat (3) step();
    @(negedge CLK);
    chk("frc_hold_sel", sel_a, 3);
    chk("frc_hold_busy", busy_a, 0);
    chk("frc_hold_rdy", rdy_a, 0);
    step();
    frc_a = 1'b0;
    vld_a = 1'b0;
    @(negedge CLK);
    chk("ret_pending_rdy", rdy_a, 0);
    step();
    for (int k = 0; k <= 4; k++) begin
      @(negedge CLK);
      chk($sformatf("ret_busy_e%0d", k), busy_a, (k < 4) ? 1 : 0);
      chk($sformatf("ret_sel_e%0d", k), sel_a, (k < 2) ? 3 : 1);
      if (k < 4) step();
    end
    chk("ret_iz", iz_a, 1);
    chk("ret_rdy", rdy_a, 1);

    // FORCE raised during SETTLE of a 0->2 switch
    req_sw_a(2'd0);
    muxin = 4'b0101;
    step();
    req_a = 2'd2;
    vld_a = 1'b1;
    step();
    vld_a = 1'b0;
    step();
    step();
    frc_a = 1'b1;
    @(negedge CLK);
    chk("fs_settle_sel", sel_a, 2);
    chk("fs_settle_busy", busy_a, 1);
    step();
    step();
    @(negedge CLK);
    chk("fs_run_busy", busy_a, 0);
    chk("fs_run_iz", iz_a, 1);
    chk("fs_run_sel", sel_a, 2);
    step();
    @(negedge CLK);
    chk("fs_drain_busy", busy_a, 1);
    chk("fs_drain_iz", iz_a, 0);
    step();
    step();
    @(negedge CLK);
    chk("fs_force_sel", sel_a, 3);
    step();
    step();
    @(negedge CLK);
    chk("fs_done_busy", busy_a, 0);
    chk("fs_done_sel", sel_a, 3);
    step();
    frc_a = 1'b0;
    repeat (6) step();
    @(negedge CLK);
    chk("fs_ret_sel", sel_a, 2);
    chk("fs_ret_busy", busy_a, 0);

    // Async reset one cycle into DRAIN
    muxin = 4'b0011;
    step();
    req_a = 2'd1;
    vld_a = 1'b1;
    step();
    vld_a = 1'b0;
    step();
    chk("ar_pre_busy", busy_a, 1);
    #2 RST = 1'b1;
    #1;
    chk("ar_sel", sel_a, 0);
    chk("ar_busy", busy_a, 0);
    chk("ar_iz", iz_a, 1);
    chk("ar_rdy", rdy_a, 1);
    step();
    RST = 1'b0;
    step();
    @(negedge CLK);
    chk("ar_post_sel", sel_a, 0);
    chk("ar_post_busy", busy_a, 0);
`ifdef QMUX_SWITCH_CNT_EN
    chk("cnt_rst", cnt_a, 0);
`endif

    // Table: request, count BUSY/ERR/IZ-low over a window, then check the settled result
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      vec_t e;
      int   nb;
      int   ne;
      int   nz;
      v = tbl[i];
      step();
      muxin = 4'hF;
      if (v.on_b) begin
        req_b = v.req;
        vld_b = 1'b1;
      end else begin
        req_a = v.req;
        vld_a = 1'b1;
      end
      @(negedge CLK);
      chk($sformatf("tbl%0d_rdy", i), v.on_b ? rdy_b : rdy_a, 1);
      exp_q.push_back(v);
      step();
      vld_a = 1'b0;
      vld_b = 1'b0;
      nb = 0;
      ne = 0;
      nz = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge CLK);
        if (v.on_b ? busy_b : busy_a) nb++;
        if (v.on_b ? err_b : err_a) ne++;
        if (!(v.on_b ? iz_b : iz_a)) nz++;
        step();
      end
      muxin = v.mux;
      #1;
      e = exp_q.pop_front();
      chk($sformatf("tbl%0d_sel", i), v.on_b ? sel_b : sel_a, e.exp_sel);
      chk($sformatf("tbl%0d_err", i), ne, e.exp_err);
      chk($sformatf("tbl%0d_busy", i), nb, e.exp_busy);
      chk($sformatf("tbl%0d_izlow", i), nz, e.exp_busy);
      chk($sformatf("tbl%0d_iz", i), v.on_b ? iz_b : iz_a, e.exp_iz);
    end

`ifdef QMUX_SWITCH_CNT_EN
    @(negedge CLK);
    chk("cnt_a", cnt_a, 4);
    chk("cnt_b", cnt_b, 1);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge CLK);
    chk("cnt_clr", cnt_a, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qmux_switch_ctrl.md
Name: qmux_switch_ctrl

Overview:
- Parametrised successor to the fixed 3-input quad clock/global mux cell.
- Selects one of NUM_IN global sources onto IZ under a sequenced, break-before-make switch controller clocked by CLK.
- Provides a valid/ready select interface, a high-speed override input (FORCE) and error flagging.
- Sits between fabric-side clock-select logic and the quad global network.

Parameters:
NUM_IN, 4, number of selectable sources (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN
DEF_SEL, 0, source selected out of reset
FORCE_CH, NUM_IN-1, source used while FORCE is high (high-speed clock path)
GAP_CYC, 2, cycles IZ is held low before the select changes (>=1)
SETTLE_CYC, 2, cycles IZ is held low after the select changes (>=1)

Ports:
CLK  input  1  controller clock
RST  input  1  asynchronous reset, active-high
MUXIN  input  NUM_IN  candidate sources
SEL_REQ  input  SEL_W  requested source index
SEL_VALID  input  1  request valid
SEL_READY  output  1  request accepted when SEL_VALID && SEL_READY at a CLK edge
FORCE  input  1  override to FORCE_CH; level-sensitive
IZ  output  1  muxed output = EN ? MUXIN[SEL_CUR] : 0 (combinational data path)
SEL_CUR  output  SEL_W  currently connected source
BUSY  output  1  high whenever state != RUN
ERR  output  1  one-cycle pulse on an out-of-range request

Behaviour:
- Reset (async, RST=1): state=RUN, EN=1, SEL_CUR=DEF_SEL, SEL_SAVED=DEF_SEL, counter=0, ERR=0, BUSY=0. IZ follows MUXIN[DEF_SEL] during and after reset.
- SEL_READY = (state==RUN) && !FORCE && !force_pending. It is combinational from the registered state and FORCE.
- States:
  - RUN: EN=1.
  - DRAIN: EN=0, counts GAP_CYC edges.
  - SETTLE: EN=0, counts SETTLE_CYC edges.
- Target determination in RUN, evaluated at each edge in priority order:
  - FORCE=1 and SEL_CUR!=FORCE_CH: target=FORCE_CH, go to DRAIN.
  - FORCE=0 and SEL_CUR!=SEL_SAVED: target=SEL_SAVED, go to DRAIN. This is the return from override.
  - Accepted request with SEL_REQ>=NUM_IN: ERR=1 for one cycle. The request is consumed. No state change.
  - Accepted request with SEL_REQ==SEL_CUR: consumed. SEL_SAVED unchanged. No switch. BUSY stays 0.
  - Accepted request, otherwise: SEL_SAVED<=SEL_REQ, target=SEL_REQ, go to DRAIN.
- Timing (accept edge = edge 0):
  - EN=0 from edge 0.
  - At edge GAP_CYC: SEL_CUR<=target, go to SETTLE.
  - At edge GAP_CYC+SETTLE_CYC: EN=1, go to RUN.
  - IZ is 0 for exactly GAP_CYC+SETTLE_CYC cycles and never shows a partial pulse of the new source.
- FORCE changes while in DRAIN/SETTLE: the in-flight switch completes unchanged. The new target is re-evaluated on the first RUN edge, which causes a back-to-back sequence. EN is high for that one RUN cycle.
- SEL_SAVED is not modified by FORCE. Requests are blocked while FORCE=1.
- Counter width = $clog2(max(GAP_CYC,SETTLE_CYC)+1). The counter resets to 0 on every state entry.
- Async reset mid-sequence: immediate return to reset values. The in-flight target is discarded.
- NUM_IN==2**SEL_W: ERR is never asserted.

Optional Feature:
- Macro: QMUX_SWITCH_CNT_EN.
- Defined: adds output SW_CNT [15:0], which increments once per completed switch (on the SETTLE->RUN edge). It saturates at 16'hFFFF and resets to 0. It adds input SW_CNT_CLR (synchronous clear); clear wins over a simultaneous increment.
- Undefined: the port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset: RST pulse with MUXIN=4'b0001 and DEF_SEL=0 -> IZ=1, SEL_CUR=0, BUSY=0, SEL_READY=1 immediately after RST falls.
- Normal switch: SEL_REQ=2 accepted at edge 0 with GAP=2, SETTLE=2 -> EN/IZ low for edges 0-3, SEL_CUR=2 at edge 2, IZ=MUXIN[2] and BUSY=0 from edge 4.
- Same/invalid select (NUM_IN=3, SEL_W=2):
  - SEL_REQ=SEL_CUR -> no BUSY, IZ uninterrupted.
  - SEL_REQ=3 -> ERR high exactly 1 cycle, SEL_CUR unchanged.
- Override: FORCE=1 in RUN with SEL_CUR=1 -> switch to FORCE_CH=3 after the 4-cycle gap. SEL_VALID ignored (SEL_READY=0) while FORCE=1. FORCE=0 -> returns to SEL_CUR=1 after another 4-cycle gap.
- FORCE asserted during SETTLE of 0->2 switch -> 0->2 completes, one RUN cycle with IZ=MUXIN[2], then DRAIN toward FORCE_CH.
- Async reset at DRAIN cycle 1 -> SEL_CUR=DEF_SEL, EN=1 without waiting for a CLK edge. With QMUX_SWITCH_CNT_EN: SW_CNT=0 after reset and 2 after two completed switches.
